// File: rtl/crypto8_pkg.sv
// Shared constants and byte helpers for the 8-bit cryptosystem.
// The encryptor and decryptor both import this package so the two ends agree.
package crypto8_pkg;

   localparam int unsigned ROT_DEFAULT       = 3;
   localparam logic [7:0]  POLY_DEFAULT      = 8'hB8;
   localparam logic [7:0]  ZERO_SEED_DEFAULT = 8'hA5;

   typedef enum logic {
      UNKEYED = 1'b0,
      KEYED   = 1'b1
   } link_state_t;

   function automatic logic [7:0] rotl8(input logic [7:0] v, input logic [2:0] r);
      logic [15:0] w;
      w = {v, v} << r;
      return w[15:8];
   endfunction

   function automatic logic [7:0] rotr8(input logic [7:0] v, input logic [2:0] r);
      logic [15:0] w;
      w = {v, v} >> r;
      return w[7:0];
   endfunction

   // Galois step: shift right, fold the feedback mask in when a one drops out.
   function automatic logic [7:0] lfsr8_next(input logic [7:0] s, input logic [7:0] poly);
      return (s >> 1) ^ (s[0] ? poly : 8'h00);
   endfunction

endpackage

// File: rtl/keystream_lfsr8.sv
// Rolling keystream register: seeded from the shared key, stepped once per byte.
// A zero seed is replaced so the register can never lock up at zero.
module keystream_lfsr8
   import crypto8_pkg::*;
#(
   parameter logic [7:0] POLY      = POLY_DEFAULT,
   parameter logic [7:0] ZERO_SEED = ZERO_SEED_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       seed_load,
   input  logic [7:0] seed,
   input  logic       advance,
   output logic [7:0] state
);

   logic [7:0] seed_safe;

   assign seed_safe = (seed == 8'h00) ? ZERO_SEED : seed;

   // Seeding takes priority over advancing; a byte is never accepted in a seed cycle anyway.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ZERO_SEED;
      end else if (seed_load) begin
         state <= seed_safe;
      end else if (advance) begin
         state <= lfsr8_next(state, POLY);
      end
   end

endmodule

// File: rtl/decrypt8_stream.sv
// Receive-side byte decryptor: XOR with the keystream, rotate right, register the result.
// Valid/ready on both sides; one byte per cycle when the consumer keeps up.
module decrypt8_stream
   import crypto8_pkg::*;
#(
   parameter int unsigned ROT       = ROT_DEFAULT,
   parameter logic [7:0]  POLY      = POLY_DEFAULT,
   parameter logic [7:0]  ZERO_SEED = ZERO_SEED_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] key,
   input  logic       key_load,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   output logic       in_ready,
   output logic       out_valid,
   output logic [7:0] out_data,
   input  logic       out_ready,
   output logic       keyed
);

   localparam logic [2:0] ROT_AMT = ROT[2:0];

   link_state_t state_q;
   link_state_t state_d;
   logic [7:0]  ks;
   logic        accept;

   keystream_lfsr8 #(
      .POLY      (POLY),
      .ZERO_SEED (ZERO_SEED)
   ) u_keystream (
      .clk       (clk),
      .rst       (rst),
      .seed_load (key_load),
      .seed      (key),
      .advance   (accept),
      .state     (ks)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= UNKEYED;
      end else begin
         state_q <= state_d;
      end
   end

   // Only reset leaves KEYED; a key_load in KEYED simply re-seeds.
   always_comb begin
      state_d = state_q;
      if (key_load) begin
         state_d = KEYED;
      end
   end

   assign keyed    = (state_q == KEYED);
   assign in_ready = keyed && !key_load && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;

   // A key_load discards whatever is pending so stale plaintext never crosses a re-key.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= 8'h00;
      end else if (key_load) begin
         out_valid <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_data  <= rotr8(in_data ^ ks, ROT_AMT);
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_decrypt8_stream.sv
// Self-checking bench for decrypt8_stream: directed test-plan vectors plus randomized traffic
// compared against a cycle-level behavioural model of the receive link.
module tb_decrypt8_stream;

   logic       clk;
   logic       rst;
   logic [7:0] key;
   logic       key_load;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_ready;
   logic       keyed;

   int assertCount;
   int failCount;

   logic       mKeyed;
   logic [7:0] mKs;
   logic       mOutValid;
   logic [7:0] mOutData;

   decrypt8_stream #(
      .ROT       (3),
      .POLY      (8'hB8),
      .ZERO_SEED (8'hA5)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .key       (key),
      .key_load  (key_load),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .keyed     (keyed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] modelRor(input logic [7:0] x);
      int v;
      v = int'(x);
      v = ((v >> 3) | (v << 5)) & 255;
      return v[7:0];
   endfunction

   function automatic logic [7:0] modelRol(input logic [7:0] x);
      int v;
      v = int'(x);
      v = ((v << 3) | (v >> 5)) & 255;
      return v[7:0];
   endfunction

   function automatic logic [7:0] modelStep(input logic [7:0] s);
      int v;
      v = int'(s) / 2;
      if (s[0]) v = v ^ 184;
      return v[7:0];
   endfunction

   task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
      end
   endtask

   // Drive one cycle: compare outputs against the model mid-cycle, then advance the model at the edge.
   task automatic applyStimulus(input logic r, input logic kl, input logic [7:0] k,
                                input logic iv, input logic [7:0] id, input logic ordy);
      logic expReady;
      rst       = r;
      key_load  = kl;
      key       = k;
      in_valid  = iv;
      in_data   = id;
      out_ready = ordy;
      @(negedge clk);
      expReady = mKeyed && !kl && (!mOutValid || ordy);
      checkOutput("in_ready", {7'd0, in_ready}, {7'd0, expReady});
      checkOutput("out_valid", {7'd0, out_valid}, {7'd0, mOutValid});
      checkOutput("out_data", out_data, mOutData);
      checkOutput("keyed", {7'd0, keyed}, {7'd0, mKeyed});
      if (r) begin
         mKeyed    = 1'b0;
         mOutValid = 1'b0;
         mOutData  = 8'h00;
         mKs       = 8'hA5;
      end else if (kl) begin
         mKeyed    = 1'b1;
         mKs       = (k == 8'h00) ? 8'hA5 : k;
         mOutValid = 1'b0;
      end else if (iv && expReady) begin
         mOutData  = modelRor(id ^ mKs);
         mOutValid = 1'b1;
         mKs       = modelStep(mKs);
      end else if (ordy) begin
         mOutValid = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] p;
      logic [7:0] c;
      assertCount = 0;
      failCount   = 0;
      rst = 1'b1; key = 8'h00; key_load = 1'b0;
      in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      mKeyed = 1'b0; mOutValid = 1'b0; mOutData = 8'h00; mKs = 8'hA5;

      // Reset values, then basic decrypt with key 01.
      applyStimulus(1, 0, 8'h00, 0, 8'h00, 1);
      applyStimulus(0, 1, 8'h01, 0, 8'h00, 1);
      applyStimulus(0, 0, 8'h00, 1, 8'h0B, 1);
      checkOutput("basic0", out_data, 8'h41);
      applyStimulus(0, 0, 8'h00, 1, 8'hAA, 1);
      checkOutput("basic1", out_data, 8'h42);
      applyStimulus(0, 0, 8'h00, 0, 8'h00, 1);

      // Zero key falls back to the fixed seed.
      applyStimulus(0, 1, 8'h00, 0, 8'h00, 1);
      applyStimulus(0, 0, 8'h00, 1, 8'hA5, 1);
      checkOutput("zerokey", out_data, 8'h00);
      applyStimulus(0, 0, 8'h00, 0, 8'h00, 1);

      // Backpressure: second byte must wait until the first is taken.
      applyStimulus(0, 1, 8'h01, 0, 8'h00, 0);
      applyStimulus(0, 0, 8'h00, 1, 8'h0B, 0);
      repeat (3) applyStimulus(0, 0, 8'h00, 1, 8'hAA, 0);
      checkOutput("hold_data", out_data, 8'h41);
      checkOutput("hold_ready", {7'd0, in_ready}, 8'h00);
      applyStimulus(0, 0, 8'h00, 1, 8'hAA, 1);
      checkOutput("release", out_data, 8'h42);
      applyStimulus(0, 0, 8'h00, 0, 8'h00, 1);

      // Unkeyed: traffic is ignored.
      applyStimulus(1, 0, 8'h00, 0, 8'h00, 1);
      repeat (5) applyStimulus(0, 0, 8'h00, 1, 8'h5A, 1);

      // Re-key while a byte is stalled.
      applyStimulus(0, 1, 8'h01, 0, 8'h00, 0);
      applyStimulus(0, 0, 8'h00, 1, 8'h0B, 0);
      applyStimulus(0, 1, 8'h01, 0, 8'h00, 0);
      checkOutput("rekey_drop", {7'd0, out_valid}, 8'h00);
      applyStimulus(0, 0, 8'h00, 1, 8'h0B, 1);
      checkOutput("rekey_data", out_data, 8'h41);

      // Reset while a byte is stalled; block stays idle until re-keyed.
      applyStimulus(0, 0, 8'h00, 1, 8'hAA, 0);
      applyStimulus(1, 0, 8'h00, 1, 8'hAA, 0);
      repeat (3) applyStimulus(0, 0, 8'h00, 1, 8'h0B, 1);
      checkOutput("rst_keyed", {7'd0, keyed}, 8'h00);
      applyStimulus(1, 1, 8'h07, 0, 8'h00, 1);
      checkOutput("rst_wins", {7'd0, keyed}, 8'h00);

      // Throughput: 256 bytes back to back so the keystream wraps once.
      applyStimulus(0, 1, 8'h01, 0, 8'h00, 1);
      for (int i = 0; i < 256; i++) begin
         p = 8'($urandom);
         c = modelRol(p) ^ mKs;
         applyStimulus(0, 0, 8'h00, 1, c, 1);
         checkOutput("stream", out_data, p);
      end
      applyStimulus(0, 0, 8'h00, 0, 8'h00, 1);

      // Randomized traffic with occasional re-keys and resets.
      for (int i = 0; i < 400; i++) begin
         applyStimulus(($urandom_range(0, 49) == 0), ($urandom_range(0, 19) == 0),
                       8'($urandom_range(0, 3) == 0 ? 0 : $urandom),
                       1'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/decrypt8_stream.md
Name: decrypt8_stream

Overview:
- Receive side of the 8-bit cryptosystem. Inverts the byte encryptor.
- Accepts ciphertext bytes over a valid/ready handshake and XORs each byte with a rolling LFSR keystream.
- Rotates the result right to recover plaintext, and presents it on a registered valid/ready output.
- Sits between the link/UART receive path and the plaintext consumer, e.g. display or LED logic on the FPGA board.

Parameters:
- ROT, 3: rotate amount; must equal the encryptor's left-rotate amount (0..7).
- POLY, 8'hB8: Galois LFSR feedback mask (x^8+x^6+x^5+x^4+1).
- ZERO_SEED, 8'hA5: seed substituted when the loaded key is 8'h00.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- key  in  8  shared secret key.
- key_load  in  1  one-cycle strobe: seed the keystream from key.
- in_valid  in  1  ciphertext byte present.
- in_data  in  8  ciphertext byte.
- in_ready  out  1  block can accept a byte this cycle.
- out_valid  out  1  plaintext byte present.
- out_data  out  8  plaintext byte.
- out_ready  in  1  consumer accepts the byte this cycle.
- keyed  out  1  keystream has been seeded since reset.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values:
  - FSM = UNKEYED, keyed=0.
  - out_valid=0, out_data=8'h00.
  - LFSR state = ZERO_SEED.
- FSM states:
  - UNKEYED -> KEYED on key_load.
  - KEYED -> KEYED on key_load (re-seed).
  - Only rst returns to UNKEYED.
- Seeding: on key_load, LFSR <= (key==0 ? ZERO_SEED : key). The keystream never holds 0.
- Keystream: the current LFSR state s is the key byte for the next accepted ciphertext byte.
  - After each accept: s <= (s>>1) ^ (s[0] ? POLY : 0).
- Decrypt: out_data <= rotr(in_data ^ s, ROT), 8-bit, no carry. Inverse of encrypt c = rotl(p, ROT) ^ s.
- Input ready: in_ready = keyed && !key_load && (!out_valid || out_ready). This is combinational from registered state and inputs, with no combinational path from in_valid.
- Accept: in_valid && in_ready at an edge.
  - out_data/out_valid update at that edge.
  - Latency is 1 cycle; sustains 1 byte/cycle with out_ready held high.
- Output hold: out_valid && !out_ready keeps out_data stable and in_ready=0.
- Output release: out_valid falls when out_ready is high and no new accept happens in the same cycle.
- key_load while out_valid=1:
  - Pending output is dropped (out_valid <= 0) and the LFSR re-seeds.
  - No byte is accepted that cycle.
- key_load with rst: rst wins.
- In UNKEYED, in_valid is ignored (in_ready=0) and out_valid stays 0.
- Reset mid-transfer: pending output is discarded and the keystream resets. The sender must re-key.
- Keystream period is 255. Wrap-around is natural; no special handling.

Decomposition:
- Package crypto8_pkg:
  - constants ROT_DEFAULT, POLY_DEFAULT, ZERO_SEED_DEFAULT;
  - functions rotl8, rotr8, lfsr8_next.
  - Shared with the encryptor so both ends agree.
- Sub-module keystream_lfsr8, holding the LFSR register:
  - inputs clk, rst, seed_load, seed, advance;
  - output state.
- The top level holds the FSM, the handshake and the output register.

Test Plan:
- Basic decrypt: rst, then key=8'h01 with key_load. Send 8'h0B then 8'hAA, out_ready=1.
  - Required: out_data 8'h41 then 8'h42, each 1 cycle after accept. Keystream runs 01 -> B8 -> 5C.
- Zero key: key=8'h00 with key_load, send 8'hA5.
  - Required: out_data=8'h00, since the seed is ZERO_SEED.
- Backpressure: key=01, out_ready=0, send 8'h0B then offer 8'hAA.
  - Required: out_valid=1 with 8'h41 held and in_ready=0.
  - Then raise out_ready: 8'hAA is accepted and out_data=8'h42 the next cycle, with no byte lost or duplicated.
- Unkeyed: after rst, assert in_valid for 5 cycles without key_load.
  - Required: in_ready=0, out_valid=0, keyed=0 throughout.
- Re-key/reset mid-stream:
  - Decrypt one byte, stall it with out_ready=0, then pulse key_load with key=01. Required: out_valid drops, and the next 8'h0B decrypts to 8'h41.
  - Repeat with rst instead. Required: keyed=0, and the block remains idle until key_load.
- Throughput: re-key to 01 and stream 255 bytes encrypted by a reference model using crypto8_pkg functions, out_ready=1.
  - Required: all plaintext matches, one output per cycle, and the keystream wraps after byte 255.
